// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO, the line starts 2 cycles after a write to an idle block.
// No backpressure: writes to a full FIFO (with no pop that edge) are dropped and latch the sticky overflow flag.
module uart_tx_buffered #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic                          sysclk,
   input  logic                          cpu_reset,
   input  logic                          uartWe,
   input  logic [7:0]                    uartData,
   output logic                          fifoFull,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
   output logic                          txBusy,
   output logic                          overflow,
   output logic                          uart_tx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [PW:0]   DEPTH     = (PW + 1)'(FIFO_DEPTH);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state;
   logic [1:0]    rst_pipe;
   logic          rst;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [7:0]    shift;
   logic [2:0]    bit_idx;
   logic [BW-1:0] baud;
   logic          baud_end;
   logic          pop;
   logic          push;
   logic [PW:0]   count_next;

   // Reset asserts immediately but releases synchronously to sysclk.
   always_ff @(posedge sysclk or posedge cpu_reset) begin
      if (cpu_reset) rst_pipe <= 2'b11;
      else           rst_pipe <= {rst_pipe[0], 1'b0};
   end
   assign rst = rst_pipe[1];

   assign baud_end = (baud == BAUD_LAST);
   assign pop      = (fifoCount != '0) && ((state == IDLE) || ((state == STOP) && baud_end));
   assign push     = uartWe && ((fifoCount != DEPTH) || pop);

   always_comb begin
      count_next = fifoCount;
      if (push && !pop)      count_next = fifoCount + 1'b1;
      else if (pop && !push) count_next = fifoCount - 1'b1;
   end

   always_ff @(posedge sysclk) begin
      if (push) mem[wr_ptr] <= uartData;
   end

   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         uart_tx   <= 1'b1;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         fifoCount <= '0;
         fifoFull  <= 1'b0;
         overflow  <= 1'b0;
         txBusy    <= 1'b0;
         shift     <= '0;
         bit_idx   <= '0;
         baud      <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         fifoCount <= count_next;
         fifoFull  <= (count_next == DEPTH);
         if (uartWe && !push) overflow <= 1'b1;
         baud   <= baud_end ? '0 : baud + 1'b1;
         // Line and busy flag lag the state by one cycle, so frames stay exactly 10 bits long.
         txBusy <= (state != IDLE) || (fifoCount != '0);
         case (state)
            IDLE: uart_tx <= 1'b1;
            START: begin
               uart_tx <= 1'b0;
               if (baud_end) begin
                  state   <= DATA;
                  bit_idx <= '0;
               end
            end
            DATA: begin
               uart_tx <= shift[0];
               if (baud_end) begin
                  shift <= shift >> 1;
                  if (bit_idx == 3'd7) state   <= STOP;
                  else                 bit_idx <= bit_idx + 1'b1;
               end
            end
            STOP: begin
               uart_tx <= 1'b1;
               if (baud_end) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         // A pop from IDLE or the final stop cycle launches the next frame with no idle gap.
         if (pop) begin
            shift <= mem[rd_ptr];
            baud  <= '0;
            state <= START;
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with 4 clocks per bit and a 4-entry FIFO.
module tb_uart_tx_buffered;

   localparam int CPB = 4;
   localparam int DEP = 4;

   logic       sysclk = 1'b0;
   logic       cpu_reset = 1'b0;
   logic       uartWe = 1'b0;
   logic [7:0] uartData = 8'h00;
   logic       fifoFull;
   logic [2:0] fifoCount;
   logic       txBusy;
   logic       overflow;
   logic       uart_tx;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 sysclk = ~sysclk;

   uart_tx_buffered #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEP)) dut (
      .sysclk   (sysclk),
      .cpu_reset(cpu_reset),
      .uartWe   (uartWe),
      .uartData (uartData),
      .fifoFull (fifoFull),
      .fifoCount(fifoCount),
      .txBusy   (txBusy),
      .overflow (overflow),
      .uart_tx  (uart_tx)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic frame_bit(input logic [7:0] b, input int k);
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      return b[k-1];
   endfunction

   // Cycle c of a frame (0 = first low cycle); samples the first and last cycle of each bit.
   task automatic check_frame(input logic [7:0] b, input int first, input int last);
      for (int c = first; c <= last; c++) begin
         if (c > first) @(negedge sysclk);
         if ((c % CPB == 0) || (c % CPB == CPB - 1))
            check($sformatf("frame_%02h_c%0d", b, c), uart_tx, frame_bit(b, c / CPB));
      end
   endtask

   task automatic do_reset();
      @(negedge sysclk);
      cpu_reset = 1'b1;
      repeat (2) @(negedge sysclk);
      cpu_reset = 1'b0;
      repeat (4) @(negedge sysclk);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_tx"}, uart_tx, 1);
      check({tag, "_busy"}, txBusy, 0);
      check({tag, "_cnt"}, fifoCount, 0);
   endtask

   initial begin
      int exp_cnt6 [6];
      int exp_cnt5 [5];
      int lows;
      int busys;
      logic [7:0] v;
      logic [7:0] tail [5];
      exp_cnt6 = '{1, 1, 2, 3, 4, 4};
      exp_cnt5 = '{1, 1, 2, 3, 4};
      tail     = '{8'h11, 8'h12, 8'h13, 8'h14, 8'hAA};

      // Asynchronous reset before any clock edge
      #2 cpu_reset = 1'b1;
      #1;
      check("rst_tx", uart_tx, 1);
      check("rst_cnt", fifoCount, 0);
      check("rst_full", fifoFull, 0);
      check("rst_busy", txBusy, 0);
      check("rst_ovf", overflow, 0);
      repeat (3) @(negedge sysclk);
      cpu_reset = 1'b0;
      repeat (4) @(negedge sysclk);

      // Single byte 0x55
      uartWe = 1'b1; uartData = 8'h55;
      @(negedge sysclk);
      uartWe = 1'b0;
      check("single_cnt_n", fifoCount, 1);
      check("single_tx_n", uart_tx, 1);
      @(negedge sysclk);
      check("single_cnt_n1", fifoCount, 0);
      check("single_tx_n1", uart_tx, 1);
      check("single_busy_n1", txBusy, 1);
      @(negedge sysclk);
      check_frame(8'h55, 0, 39);
      check("single_busy_n41", txBusy, 1);
      @(negedge sysclk);
      check_idle("single_end");

      // Back-to-back 0x41, 0x42, 0x43
      uartWe = 1'b1; uartData = 8'h41;
      @(negedge sysclk);
      check("b2b_cnt0", fifoCount, 1);
      uartData = 8'h42;
      @(negedge sysclk);
      check("b2b_cnt1", fifoCount, 1);
      uartData = 8'h43;
      @(negedge sysclk);
      check("b2b_cnt2", fifoCount, 2);
      uartWe = 1'b0;
      check_frame(8'h41, 0, 39);
      @(negedge sysclk);
      check_frame(8'h42, 0, 39);
      @(negedge sysclk);
      check_frame(8'h43, 0, 39);
      @(negedge sysclk);
      check_idle("b2b_end");

      // Overflow: six writes while idle, the sixth is dropped
      do_reset();
      uartWe = 1'b1;
      for (int i = 0; i < 6; i++) begin
         uartData = 8'(i);
         @(negedge sysclk);
         check($sformatf("ovf_cnt%0d", i), fifoCount, 32'(exp_cnt6[i]));
         check($sformatf("ovf_full%0d", i), fifoFull, (i >= 4) ? 1 : 0);
         check($sformatf("ovf_flag%0d", i), overflow, (i == 5) ? 1 : 0);
      end
      uartWe = 1'b0;
      check_frame(8'h00, 3, 39);
      for (int i = 1; i < 5; i++) begin
         @(negedge sysclk);
         check_frame(8'(i), 0, 39);
      end
      @(negedge sysclk);
      check_idle("ovf_end");
      check("ovf_sticky", overflow, 1);

      // Write into a full FIFO on the stop-end pop edge
      do_reset();
      check("fullpop_ovf_rst", overflow, 0);
      uartWe = 1'b1;
      for (int i = 0; i < 5; i++) begin
         uartData = 8'h10 + 8'(i);
         @(negedge sysclk);
         check($sformatf("fullpop_cnt%0d", i), fifoCount, 32'(exp_cnt5[i]));
      end
      uartWe = 1'b0;
      check("fullpop_full", fifoFull, 1);
      check_frame(8'h10, 2, 38);
      uartWe = 1'b1; uartData = 8'hAA;
      @(negedge sysclk);
      uartWe = 1'b0;
      check("fullpop_cnt_after", fifoCount, 4);
      check("fullpop_full_after", fifoFull, 1);
      check("fullpop_ovf_after", overflow, 0);
      check_frame(8'h10, 39, 39);
      for (int i = 0; i < 5; i++) begin
         @(negedge sysclk);
         check_frame(tail[i], 0, 39);
      end
      @(negedge sysclk);
      check_idle("fullpop_end");
      check("fullpop_ovf_end", overflow, 0);

      // Reset during data bit 3 of 0x0F with two bytes queued
      uartWe = 1'b1;
      uartData = 8'h0F; @(negedge sysclk);
      uartData = 8'h01; @(negedge sysclk);
      uartData = 8'h02; @(negedge sysclk);
      uartWe = 1'b0;
      check("midrst_cnt", fifoCount, 2);
      check_frame(8'h0F, 0, 17);
      cpu_reset = 1'b1;
      #1;
      check("midrst_tx", uart_tx, 1);
      check("midrst_cnt0", fifoCount, 0);
      check("midrst_ovf", overflow, 0);
      check("midrst_busy", txBusy, 0);
      @(negedge sysclk);
      cpu_reset = 1'b0;
      lows = 0;
      busys = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge sysclk);
         if (uart_tx !== 1'b1) lows++;
         if (txBusy !== 1'b0) busys++;
      end
      check("midrst_line_quiet", lows, 0);
      check("midrst_busy_quiet", busys, 0);

      // Ten paced bytes wrap the pointers of the 4-entry FIFO
      for (int i = 0; i < 10; i++) begin
         v = 8'(i * 37 + 3);
         uartWe = 1'b1; uartData = v;
         @(negedge sysclk);
         uartWe = 1'b0;
         check($sformatf("wrap_cnt%0d", i), fifoCount, 1);
         repeat (2) @(negedge sysclk);
         check_frame(v, 0, 39);
         @(negedge sysclk);
         check($sformatf("wrap_tx_idle%0d", i), uart_tx, 1);
         check($sformatf("wrap_busy%0d", i), txBusy, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
